// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch port, data port and shared-memory port of mem_port_arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ready;
  logic [DATA_W-1:0] dm_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_ready, if_rdata, dm_ready, dm_rdata,
           mem_addr, mem_wdata, mem_read, mem_write, busy
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_ready, if_rdata, dm_ready, dm_rdata,
           mem_addr, mem_wdata, mem_read, mem_write, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / data) arbiter onto a single-ported memory, IDLE->ACCESS->DONE.
// Define ARB_ROUND_ROBIN_EN to alternate on contention; otherwise the data port always wins.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic                clk,
  input logic                reset,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              we_q, we_d;
  logic              gnt_dm_q, gnt_dm_d;
  logic              pick_dm;

`ifdef ARB_ROUND_ROBIN_EN
  // last_dm_q=1 means the data port won the previous grant
  logic last_dm_q, last_dm_d;

  always_comb begin
    pick_dm = bus.dm_req;
    if (bus.if_req && bus.dm_req) pick_dm = !last_dm_q;
  end
`else
  assign pick_dm = bus.dm_req;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    gnt_dm_d   = gnt_dm_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_dm_d  = last_dm_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.if_req || bus.dm_req) begin
          gnt_dm_d = pick_dm;
          addr_d   = pick_dm ? bus.dm_addr : bus.if_addr;
          we_d     = pick_dm && bus.dm_we;
          if (pick_dm && bus.dm_we) wdata_d = bus.dm_wdata;
`ifdef ARB_ROUND_ROBIN_EN
          last_dm_d = pick_dm;
`endif
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        if (!we_q) begin
          if (gnt_dm_q) dm_rdata_d = bus.mem_rdata;
          else          if_rdata_d = bus.mem_rdata;
        end
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      gnt_dm_q   <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_dm_q  <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      gnt_dm_q   <= gnt_dm_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_dm_q  <= last_dm_d;
`endif
    end
  end

  // Strobes and ready pulses decode straight from state so reset kills them without a clock.
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_read  = (state_q == ACCESS) && !we_q;
  assign bus.mem_write = (state_q == ACCESS) &&  we_q;
  assign bus.if_ready  = (state_q == DONE) && !gnt_dm_q;
  assign bus.dm_ready  = (state_q == DONE) &&  gnt_dm_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table of single transactions plus
// hand-written reset-mid-store and contention sequences.
module tb_mem_port_arbiter;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Memory returns a fixed pattern of the address: addr 0 reads 0x3C05ABCD.
  assign bus.mem_rdata = bus.mem_addr ^ 32'h3C05ABCD;

  always #5 clk = ~clk;

  typedef struct {
    logic        dm;
    logic        we;
    logic        drop;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } vec_t;

  vec_t        vecs[6];
  logic [31:0] exp_if;
  logic [31:0] exp_dm;
  logic [12:0] e_if_rdy;
  logic [12:0] e_dm_rdy;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drop_reqs();
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    if (v.dm) begin
      bus.dm_req   = 1'b1;
      bus.dm_we    = v.we;
      bus.dm_addr  = v.addr;
      bus.dm_wdata = v.wdata;
    end else begin
      bus.if_req  = 1'b1;
      bus.if_addr = v.addr;
    end
    @(posedge clk); #1;
    chk1 ("acc_busy",  bus.busy, 1'b1);
    chk32("acc_addr",  bus.mem_addr, v.addr);
    chk1 ("acc_read",  bus.mem_read,  !(v.dm && v.we));
    chk1 ("acc_write", bus.mem_write,   v.dm && v.we);
    if (v.dm && v.we) chk32("acc_wdata", bus.mem_wdata, v.wdata);
    if (v.drop) drop_reqs();
    @(posedge clk); #1;
    if (!(v.dm && v.we)) begin
      if (v.dm) exp_dm = v.rdata;
      else      exp_if = v.rdata;
    end
    chk1 ("done_if_ready", bus.if_ready, !v.dm);
    chk1 ("done_dm_ready", bus.dm_ready,  v.dm);
    chk1 ("done_strobes",  bus.mem_read | bus.mem_write, 1'b0);
    chk32("done_if_rdata", bus.if_rdata, exp_if);
    chk32("done_dm_rdata", bus.dm_rdata, exp_dm);
    drop_reqs();
    @(posedge clk); #1;
    chk1 ("idle_busy",    bus.busy, 1'b0);
    chk1 ("idle_ready",   bus.if_ready | bus.dm_ready, 1'b0);
    chk32("idle_if_hold", bus.if_rdata, exp_if);
    chk32("idle_dm_hold", bus.dm_rdata, exp_dm);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    clk    = 1'b0;
    reset  = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
    exp_if = '0;
    exp_dm = '0;

    //        dm    we    drop  addr           wdata          rdata
    vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0,         32'h3C05_ABCD};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'h0,         32'h3C05_AB8D};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0,         32'hC3FA_5431};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h0000_0003, 32'hA5A5_A5A5, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h0000_0003, 32'h0,         32'h3C05_ABCE};

    // Reset state, checked before any clock edge
    #2;
    chk1 ("rst_busy",     bus.busy, 1'b0);
    chk1 ("rst_if_ready", bus.if_ready, 1'b0);
    chk1 ("rst_dm_ready", bus.dm_ready, 1'b0);
    chk1 ("rst_mem_read", bus.mem_read, 1'b0);
    chk1 ("rst_mem_write",bus.mem_write, 1'b0);
    chk32("rst_mem_addr", bus.mem_addr, 32'h0);
    chk32("rst_mem_wdata",bus.mem_wdata, 32'h0);
    chk32("rst_if_rdata", bus.if_rdata, 32'h0);
    chk32("rst_dm_rdata", bus.dm_rdata, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Reset in the middle of a store
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h200; bus.dm_wdata = 32'h1234_5678;
    @(posedge clk); #1;
    chk1("mid_write_on", bus.mem_write, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk1 ("mid_write_off", bus.mem_write, 1'b0);
    chk1 ("mid_busy",      bus.busy, 1'b0);
    chk32("mid_addr",      bus.mem_addr, 32'h0);
    drop_reqs();
    exp_if = '0;
    exp_dm = '0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk1("mid_no_ready", bus.dm_ready, 1'b0);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk1("post_rst_busy",  bus.busy, 1'b0);
    chk1("post_rst_ready", bus.dm_ready | bus.if_ready, 1'b0);
    @(negedge clk);

    // Contention: both held; ready cycles counted from the first sampling edge
`ifdef ARB_ROUND_ROBIN_EN
    e_if_rdy = 13'b0_0001_0000_0100;
    e_dm_rdy = 13'b0_1000_0010_0000;
`else
    e_if_rdy = 13'b0_1001_0000_0000;
    e_dm_rdy = 13'b0_0000_0010_0100;
`endif
    bus.if_req = 1'b1; bus.if_addr = 32'h20;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h30;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      chk1($sformatf("cont_if_ready_c%0d", k), bus.if_ready, e_if_rdy[k]);
      chk1($sformatf("cont_dm_ready_c%0d", k), bus.dm_ready, e_dm_rdy[k]);
      if (e_if_rdy[k]) chk32($sformatf("cont_if_rdata_c%0d", k), bus.if_rdata, 32'h3C05_ABED);
      if (e_dm_rdy[k]) chk32($sformatf("cont_dm_rdata_c%0d", k), bus.dm_rdata, 32'h3C05_ABFD);
`ifndef ARB_ROUND_ROBIN_EN
      if (k == 5) bus.dm_req = 1'b0;
`endif
    end
    drop_reqs();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk1("end_busy", bus.busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
